// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation and
// vectoring modes over the full circle via quadrant pre-rotation.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start_i          request, accepted when no iteration is in flight
//   mode_i           0 = rotation, 1 = vectoring
//   x_i, y_i         signed WIDTH-bit input vector
//   z_i              signed 16-bit binary angle (0x4000 = +90 deg)
//   n_i              requested micro-rotations, clamped to ITER_MAX
//   busy_o           high from capture until the engine is idle again
//   valid_o          one-cycle result strobe
//   x_o, y_o         signed WIDTH+2-bit results (unscaled by K_n)
//   z_o              signed 16-bit result angle
module cordic_iter_core #(
  parameter int WIDTH    = 16,
  parameter int ITER_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [15:0]      z_i,
  input  logic [4:0]              n_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic signed [WIDTH+1:0] x_o,
  output logic signed [WIDTH+1:0] y_o,
  output logic signed [15:0]      z_o
);

  localparam int W = WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] N_MAX = 5'(ITER_MAX);

  localparam logic signed [15:0] QTR_P = 16'sh4000;
  localparam logic signed [15:0] QTR_N = 16'shC000;

  function automatic logic signed [15:0] atan_lut(
    input logic [4:0] idx
  );
    case (idx)
      5'd0:    atan_lut = 16'sd8192;
      5'd1:    atan_lut = 16'sd4836;
      5'd2:    atan_lut = 16'sd2555;
      5'd3:    atan_lut = 16'sd1297;
      5'd4:    atan_lut = 16'sd651;
      5'd5:    atan_lut = 16'sd326;
      5'd6:    atan_lut = 16'sd163;
      5'd7:    atan_lut = 16'sd81;
      5'd8:    atan_lut = 16'sd41;
      5'd9:    atan_lut = 16'sd20;
      5'd10:   atan_lut = 16'sd10;
      5'd11:   atan_lut = 16'sd5;
      5'd12:   atan_lut = 16'sd3;
      5'd13:   atan_lut = 16'sd1;
      5'd14:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  logic [1:0]          state;
  logic                mode;
  logic [4:0]          cnt;
  logic [4:0]          n;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [15:0]  z;

  logic signed [W-1:0] xe;
  logic signed [W-1:0] ye;
  logic signed [W-1:0] xp;
  logic signed [W-1:0] yp;
  logic signed [15:0]  zp;
  logic [4:0]          n_cap;

  // Quadrant pre-rotation folds the input into |angle| <= 90 deg,
  // the convergence range of the micro-rotation sequence.
  always_comb begin
    xe    = {{2{x_i[WIDTH-1]}}, x_i};
    ye    = {{2{y_i[WIDTH-1]}}, y_i};
    xp    = xe;
    yp    = ye;
    zp    = mode_i ? 16'sd0 : z_i;
    n_cap = (n_i > N_MAX) ? N_MAX : n_i;
    unique case (1'b1)
      (!mode_i && z_i > QTR_P): begin
        xp = -ye;
        yp = xe;
        zp = z_i - QTR_P;
      end
      (!mode_i && z_i < QTR_N): begin
        xp = ye;
        yp = -xe;
        zp = z_i + QTR_P;
      end
      (mode_i && xe[W-1] && !ye[W-1]): begin
        xp = ye;
        yp = -xe;
        zp = QTR_P;
      end
      (mode_i && xe[W-1] && ye[W-1]): begin
        xp = -ye;
        yp = xe;
        zp = QTR_N;
      end
      default: ;
    endcase
  end

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;
  logic signed [W-1:0] xn;
  logic signed [W-1:0] yn;
  logic signed [15:0]  at;
  logic signed [15:0]  zn;
  logic                d_pos;

  always_comb begin
    xs    = x >>> cnt;
    ys    = y >>> cnt;
    at    = atan_lut(cnt);
    d_pos = mode ? y[W-1] : !z[15];
    if (d_pos) begin
      xn = x - ys;
      yn = y + xs;
      zn = z - at;
    end else begin
      xn = x + ys;
      yn = y - xs;
      zn = z + at;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      x_o     <= '0;
      y_o     <= '0;
      z_o     <= '0;
      mode    <= 1'b0;
      cnt     <= '0;
      n       <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_ITER: begin
          x <= xn;
          y <= yn;
          z <= zn;
          if (cnt == n - 5'd1) begin
            x_o     <= xn;
            y_o     <= yn;
            z_o     <= zn;
            valid_o <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          // DONE doubles as an accept slot so a held start_i
          // streams one result every n+1 cycles.
          if (start_i) begin
            busy_o <= 1'b1;
            mode   <= mode_i;
            n      <= n_cap;
            cnt    <= '0;
            x      <= xp;
            y      <= yp;
            z      <= zp;
            if (n_cap == 5'd0) begin
              x_o     <= xp;
              y_o     <= yp;
              z_o     <= zp;
              valid_o <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_ITER;
            end
          end else begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Randomised and directed bench for cordic_iter_core against an
// arithmetic reference model of the CORDIC recurrence.
module tb_cordic_iter_core;

  localparam int WIDTH    = 16;
  localparam int ITER_MAX = 16;
  localparam int W        = WIDTH + 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start_i = 1'b0;
  logic                    mode_i = 1'b0;
  logic signed [WIDTH-1:0] x_i = '0;
  logic signed [WIDTH-1:0] y_i = '0;
  logic signed [15:0]      z_i = '0;
  logic [4:0]              n_i = '0;
  logic                    busy_o;
  logic                    valid_o;
  logic signed [W-1:0]     x_o;
  logic signed [W-1:0]     y_o;
  logic signed [15:0]      z_o;

  cordic_iter_core #(
    .WIDTH(WIDTH),
    .ITER_MAX(ITER_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .mode_i(mode_i),
    .x_i(x_i),
    .y_i(y_i),
    .z_i(z_i),
    .n_i(n_i),
    .busy_o(busy_o),
    .valid_o(valid_o),
    .x_o(x_o),
    .y_o(y_o),
    .z_o(z_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163,
                        81, 41, 20, 10, 5, 3, 1, 1, 0};

  task automatic chk(input string tag, input int obs,
                     input int exp, input int tol = 0);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (tol %0d)",
               tag, obs, exp, tol);
    end
  endtask

  function automatic int wrap(input int v, input int bits);
    int s;
    s = 32 - bits;
    return (v <<< s) >>> s;
  endfunction

  function automatic void ref_model(input bit m, input int x,
                                    input int y, input int z,
                                    input int n, output int rx,
                                    output int ry, output int rz);
    int xv, yv, zv, t, nn, xs, ys;
    xv = x;
    yv = y;
    zv = m ? 0 : z;
    nn = (n > ITER_MAX) ? ITER_MAX : n;
    if (m) begin
      if (xv < 0 && yv >= 0) begin
        t = xv; xv = yv; yv = -t; zv = 16384;
      end else if (xv < 0) begin
        t = xv; xv = -yv; yv = t; zv = -16384;
      end
    end else if (zv > 16384) begin
      t = xv; xv = -yv; yv = t; zv = zv - 16384;
    end else if (zv < -16384) begin
      t = xv; xv = yv; yv = -t; zv = zv + 16384;
    end
    for (int k = 0; k < nn; k++) begin
      xs = xv >>> k;
      ys = yv >>> k;
      if (m ? (yv < 0) : (zv >= 0)) begin
        xv = wrap(xv - ys, W);
        yv = wrap(yv + xs, W);
        zv = wrap(zv - atan_tab[k], 16);
      end else begin
        xv = wrap(xv + ys, W);
        yv = wrap(yv - xs, W);
        zv = wrap(zv + atan_tab[k], 16);
      end
    end
    rx = xv;
    ry = yv;
    rz = zv;
  endfunction

  // Starts an operation from an idle/done slot and waits for valid_o.
  // lat counts edges from the capture edge to the result edge.
  task automatic run_op(input bit m, input int x, input int y,
                        input int z, input int n,
                        output int rx, output int ry,
                        output int rz, output int lat);
    mode_i  = m;
    x_i     = 16'(x);
    y_i     = 16'(y);
    z_i     = 16'(z);
    n_i     = 5'(n);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_at_capture", int'(busy_o), 1);
    lat = -1;
    rx = 0;
    ry = 0;
    rz = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o) begin
        lat = c;
        rx = int'(x_o);
        ry = int'(y_o);
        rz = int'(z_o);
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) chk("valid_timeout", lat, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int rx, ry, rz, lat, ex, ey, ez, cnt, nr;
    int m, x, y, z, n;
    int edges [$];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_x", int'(x_o), 0);
    chk("rst_y", int'(y_o), 0);
    chk("rst_z", int'(z_o), 0);

    run_op(0, 10000, 0, 'h2000, 16, rx, ry, rz, lat);
    chk("rot45_lat", lat, 16);
    chk("rot45_x", rx, 11645, 4);
    chk("rot45_y", ry, 11645, 4);
    chk("rot45_z", rz, 0, 2);
    @(posedge clk); #1;
    chk("rot45_pulse", int'(valid_o), 0);
    chk("rot45_idle", int'(busy_o), 0);

    run_op(0, 10000, 0, -32768, 16, rx, ry, rz, lat);
    chk("rot180_x", rx, -16468, 4);
    chk("rot180_y", ry, 0, 4);
    run_op(0, 10000, 0, 'h4000, 16, rx, ry, rz, lat);
    chk("rot90_x", rx, 0, 4);
    chk("rot90_y", ry, 16468, 4);

    run_op(1, -10000, 10000, 0, 16, rx, ry, rz, lat);
    chk("vec135_z", rz, 24576, 2);
    chk("vec135_x", rx, 23289, 4);
    chk("vec135_y", ry, 0, 4);
    run_op(1, -10000, -10000, 0, 16, rx, ry, rz, lat);
    chk("vec225_z", rz, -24576, 2);

    run_op(0, 100, 50, 'h5000, 0, rx, ry, rz, lat);
    chk("n0_lat", lat, 0);
    chk("n0_x", rx, -50);
    chk("n0_y", ry, 100);
    chk("n0_z", rz, 'h1000);
    @(posedge clk); #1;
    chk("n0_pulse", int'(valid_o), 0);

    run_op(0, 1234, -4321, 777, 31, rx, ry, rz, lat);
    ref_model(0, 1234, -4321, 777, 31, ex, ey, ez);
    chk("n31_lat", lat, 16);
    chk("n31_x", rx, ex);

    // start_i pulsed mid-flight must be ignored
    mode_i  = 1'b0;
    x_i     = 16'sd10000;
    y_i     = 16'sd0;
    z_i     = 16'sh2000;
    n_i     = 5'd16;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mode_i  = 1'b1;
    x_i     = -16'sd5000;
    y_i     = 16'sd3000;
    z_i     = -16'sh3000;
    n_i     = 5'd4;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (valid_o) begin
        if (cnt == 0) begin
          rx = int'(x_o);
          ry = int'(y_o);
          rz = int'(z_o);
        end
        cnt++;
      end
      @(posedge clk); #1;
    end
    ref_model(0, 10000, 0, 'h2000, 16, ex, ey, ez);
    chk("busy_ign_count", cnt, 1);
    chk("busy_ign_x", rx, ex);
    chk("busy_ign_y", ry, ey);
    chk("busy_ign_z", rz, ez);

    // held start_i: pulses every n+1 cycles
    mode_i  = 1'b0;
    x_i     = 16'sd3000;
    y_i     = 16'sd2000;
    z_i     = 16'sh1000;
    n_i     = 5'd3;
    start_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (valid_o) edges.push_back(c);
    end
    start_i = 1'b0;
    chk("b2b_count", edges.size(), 5);
    if (edges.size() >= 4) begin
      chk("b2b_first", edges[0], 3);
      for (int k = 1; k < 4; k++)
        chk("b2b_gap", edges[k] - edges[k-1], 4);
    end
    cnt = 0;
    while (busy_o && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("b2b_drain", int'(busy_o), 0);

    // reset during iteration 5
    mode_i  = 1'b0;
    x_i     = 16'sd8000;
    y_i     = 16'sd1000;
    z_i     = 16'sh1800;
    n_i     = 5'd16;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_x", int'(x_o), 0);
    chk("abort_y", int'(y_o), 0);
    chk("abort_z", int'(z_o), 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid_o) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", cnt, 0);
    run_op(1, 7000, -3000, 0, 12, rx, ry, rz, lat);
    ref_model(1, 7000, -3000, 0, 12, ex, ey, ez);
    chk("post_rst_x", rx, ex);
    chk("post_rst_y", ry, ey);
    chk("post_rst_z", rz, ez);
    chk("post_rst_lat", lat, 12);

    for (int t = 0; t < 40; t++) begin
      m = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 65535)) - 32768;
      y = int'($urandom_range(0, 65535)) - 32768;
      z = int'($urandom_range(0, 65535)) - 32768;
      n = int'($urandom_range(0, 31));
      run_op(m[0], x, y, z, n, rx, ry, rz, lat);
      ref_model(m[0], x, y, z, n, ex, ey, ez);
      nr = (n > ITER_MAX) ? ITER_MAX : n;
      chk("rand_lat", lat, nr);
      chk("rand_x", rx, ex);
      chk("rand_y", ry, ey);
      chk("rand_z", rz, ez);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
